// File: rtl/gpi_debounce.sv
// gpi_debounce: per-bit synchroniser and hold-time debouncer in front of the GPI PIO,
// with registered single-cycle rise/fall strobes and an any_change summary.
module gpi_debounce #(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               CNT_WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);
    localparam logic STABLE   = 1'b0;
    localparam logic COUNTING = 1'b1;
    localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     state_q, state_d, clean_q, clean_d;
    logic [WIDTH-1:0]     rise_q, rise_d, fall_q, fall_d;
    logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [WIDTH];
    logic                 any_q;
    logic [WIDTH-1:0]     samp;

    assign samp = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (samp[i] == clean_q[i]) begin
                state_d[i] = STABLE;
                cnt_d[i]   = '0;
            end else if (state_q[i] == COUNTING ? cnt_q[i] == TERM : DEBOUNCE_CYCLES == 1) begin
                // terminal compare precedes the increment, so the counter never wraps
                clean_d[i] = samp[i];
                rise_d[i]  = samp[i];
                fall_d[i]  = ~samp[i];
                state_d[i] = STABLE;
                cnt_d[i]   = '0;
            end else begin
                state_d[i] = COUNTING;
                cnt_d[i]   = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VALUE;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            state_q <= {WIDTH{STABLE}};
            clean_q <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            sync_q[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            cnt_q   <= cnt_d;
            state_q <= state_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= |{rise_d, fall_d};
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_q;
endmodule

// File: tb/tb_gpi_debounce.sv
// tb_gpi_debounce: directed table-driven bench for gpi_debounce (DEBOUNCE_CYCLES=8)
// plus a DEBOUNCE_CYCLES=1 instance.
module tb_gpi_debounce;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] raw = '0, raw1 = '0;
    logic [3:0] clean, rise, fall, clean1, rise1, fall1;
    logic       any, any1;

    logic [3:0] racc, facc, r1acc, f1acc;
    int         acnt, a1cnt;
    int         checks = 0, errors = 0;

    typedef struct {
        logic [3:0] raw;
        int         n;
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] fall;
        int         anyc;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    gpi_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_WIDTH(4), .RESET_VALUE(4'b0000)) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw), .clean_out(clean),
        .rise_pulse(rise), .fall_pulse(fall), .any_change(any)
    );

    gpi_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(4), .RESET_VALUE(4'b0000)) dut1 (
        .clk(clk), .reset_n(reset_n), .raw_in(raw1), .clean_out(clean1),
        .rise_pulse(rise1), .fall_pulse(fall1), .any_change(any1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        racc = '0; facc = '0; acnt = 0;
        r1acc = '0; f1acc = '0; a1cnt = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            racc  |= rise;
            facc  |= fall;
            acnt  += int'(any);
            r1acc |= rise1;
            f1acc |= fall1;
            a1cnt += int'(any1);
        end
    endtask

    task automatic add(input logic [3:0] r, input int n, input logic [3:0] c,
                       input logic [3:0] ri, input logic [3:0] fa, input int a);
        vec_t v;
        v.raw = r; v.n = n; v.clean = c; v.rise = ri; v.fall = fa; v.anyc = a;
        tv.push_back(v);
    endtask

    initial begin
        add(4'b0000, 3, 4'b0000, 4'b0000, 4'b0000, 0);
        add(4'b0001, 9, 4'b0000, 4'b0000, 4'b0000, 0);
        add(4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 1);
        add(4'b0001, 5, 4'b0001, 4'b0000, 4'b0000, 0);
        add(4'b0011, 10, 4'b0011, 4'b0010, 4'b0000, 1);
        add(4'b0011, 2, 4'b0011, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 14; k++)
            add(k % 2 == 0 ? 4'b0001 : 4'b0011, 3, 4'b0011, 4'b0000, 4'b0000, 0);
        add(4'b0001, 9, 4'b0011, 4'b0000, 4'b0000, 0);
        add(4'b0001, 1, 4'b0001, 4'b0000, 4'b0010, 1);
        add(4'b0101, 7, 4'b0001, 4'b0000, 4'b0000, 0);
        add(4'b0001, 12, 4'b0001, 4'b0000, 4'b0000, 0);
        add(4'b0101, 8, 4'b0001, 4'b0000, 4'b0000, 0);
        add(4'b0001, 4, 4'b0101, 4'b0100, 4'b0000, 1);
        add(4'b0001, 5, 4'b0101, 4'b0000, 4'b0000, 0);
        add(4'b0001, 1, 4'b0001, 4'b0000, 4'b0100, 1);
        add(4'b0000, 10, 4'b0000, 4'b0000, 4'b0001, 1);
        add(4'b1111, 9, 4'b0000, 4'b0000, 4'b0000, 0);
        add(4'b1111, 1, 4'b1111, 4'b1111, 4'b0000, 1);
        add(4'b1111, 3, 4'b1111, 4'b0000, 4'b0000, 0);

        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("reset clean", 32'(clean), 32'(4'b0000));
        chk("reset rise", 32'(rise), 32'(4'b0000));
        chk("reset fall", 32'(fall), 32'(4'b0000));
        chk("reset any", 32'(any), 32'(1'b0));
        #3 reset_n = 1'b1;

        foreach (tv[v]) begin
            raw = tv[v].raw;
            clr();
            tick(tv[v].n);
            chk($sformatf("v%0d clean", v), 32'(clean), 32'(tv[v].clean));
            chk($sformatf("v%0d rise", v), 32'(racc), 32'(tv[v].rise));
            chk($sformatf("v%0d fall", v), 32'(facc), 32'(tv[v].fall));
            chk($sformatf("v%0d anycnt", v), 32'(acnt), 32'(tv[v].anyc));
        end

        // abort a falling count on bit 3 at cnt=5 with an asynchronous reset
        raw = 4'b0111;
        clr();
        tick(7);
        chk("pre-reset clean", 32'(clean), 32'(4'b1111));
        #3 reset_n = 1'b0;
        #1;
        chk("async reset clean", 32'(clean), 32'(4'b0000));
        chk("async reset rise", 32'(rise), 32'(4'b0000));
        chk("async reset fall", 32'(fall), 32'(4'b0000));
        chk("async reset any", 32'(any), 32'(1'b0));
        chk("aborted fall", 32'(facc), 32'(4'b0000));
        raw = 4'b1111;
        #10 reset_n = 1'b1;
        clr();
        tick(9);
        chk("restart early clean", 32'(clean), 32'(4'b0000));
        chk("restart early pulses", 32'(acnt), 32'd0);
        tick(1);
        chk("restart clean", 32'(clean), 32'(4'b1111));
        chk("restart rise", 32'(racc), 32'(4'b1111));
        chk("restart fall", 32'(facc), 32'(4'b0000));
        chk("restart anycnt", 32'(acnt), 32'd1);

        raw1 = 4'b1010;
        clr();
        tick(2);
        chk("d1 early clean", 32'(clean1), 32'(4'b0000));
        tick(1);
        chk("d1 rise clean", 32'(clean1), 32'(4'b1010));
        chk("d1 rise", 32'(r1acc), 32'(4'b1010));
        chk("d1 rise any", 32'(a1cnt), 32'd1);
        raw1 = 4'b0010;
        clr();
        tick(2);
        chk("d1 hold clean", 32'(clean1), 32'(4'b1010));
        tick(2);
        chk("d1 fall clean", 32'(clean1), 32'(4'b0010));
        chk("d1 fall", 32'(f1acc), 32'(4'b1000));
        chk("d1 fall norise", 32'(r1acc), 32'(4'b0000));
        chk("d1 fall any", 32'(a1cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- Multi-channel input conditioner that sits directly upstream of the GPI PIO (DIP switch / push-button port).
- Per bit: synchronises raw board-level inputs into clk, then rejects bounce and glitches shorter than a programmable hold time.
- clean_out drives the PIO in_port, so the PIO edge-capture logic sees exactly one edge per real switch change.
- Also emits single-cycle rise/fall strobes for logic that bypasses the PIO.

Parameters:
- WIDTH, 4, number of input channels.
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- DEBOUNCE_CYCLES, 50000, clocks of continuous stable new level before acceptance; must be >= 1.
- CNT_WIDTH, 16, per-channel counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.
- RESET_VALUE, 0, WIDTH-bit reset level for synchroniser, clean_out and counters' reference.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- raw_in  in  WIDTH  asynchronous switch inputs.
- clean_out  out  WIDTH  debounced level, registered.
- rise_pulse  out  WIDTH  one-cycle strobe when clean_out bit goes 0->1.
- fall_pulse  out  WIDTH  one-cycle strobe when clean_out bit goes 1->0.
- any_change  out  1  OR of all rise_pulse and fall_pulse bits, registered with them.

Behaviour:
Reset:
- Reset is asynchronous and active-low; clk is the only clock.
- While reset_n=0: sync chain = RESET_VALUE, clean_out = RESET_VALUE, all counters = 0, every channel in STABLE, rise/fall/any_change = 0.
- Reset asserted mid-count aborts the count with no pulse.

Synchroniser:
- SYNC_STAGES flops per bit; sync_q is the last stage. No combinational path from raw_in to any output.

Per-channel FSM, two states, evaluated each rising clk edge:
- STABLE (cnt=0):
  - sync_q == clean_out: stay.
  - sync_q != clean_out: go to COUNTING with cnt <= 1.
  - When DEBOUNCE_CYCLES=1, instead update clean_out immediately and stay in STABLE.
- COUNTING:
  - sync_q == clean_out: glitch. cnt <= 0, go to STABLE, no output change.
  - sync_q != clean_out and cnt == DEBOUNCE_CYCLES-1: clean_out <= sync_q, cnt <= 0, go to STABLE, assert the matching rise/fall pulse on the same edge.
  - Otherwise: cnt <= cnt+1.

Timing and pulses:
- Latency: a raw_in change held stable appears on clean_out exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- Pulses are high for exactly one cycle and are never asserted together for the same bit.
- Channels are fully independent. Simultaneous acceptances on several bits produce simultaneous pulses; any_change is high for one cycle.
- Counter never wraps: the terminal compare precedes increment.
- If raw_in differs from RESET_VALUE at reset release, it is debounced normally and produces one pulse. The downstream edge capture sees this as a genuine edge.

Test Plan:
- WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8. Reset, raw_in=0000 -> clean_out=0000, pulses 0, any_change 0.
- raw_in[0] 0->1, held -> clean_out[0]=1 exactly 10 edges after the first sampling edge; rise_pulse=0001 for one cycle; any_change one cycle; fall_pulse stays 0.
- raw_in[1] toggles 1->0->1 every 3 clocks for 40 clocks, starting from clean=1 -> clean_out[1] stays 1, no pulses. Then hold 0 -> fall_pulse=0010 once, 10 edges after the last transition is sampled.
- raw_in[2] high for exactly 7 clocks (post-sync) then back low -> no change. High for exactly 8 -> clean_out[2]=1, rise_pulse[2] one cycle.
- raw_in 0000->1111 in one cycle -> all four bits change on the same edge; rise_pulse=1111 and any_change=1 for one cycle.
- Counting in progress with cnt=5: assert reset_n=0 asynchronously mid-cycle. Outputs go to RESET_VALUE immediately, no pulse. After release with raw held at 1 -> full 10-edge latency restarts and produces one rise pulse.
- DEBOUNCE_CYCLES=1 build -> clean_out follows raw_in with 3-edge latency, one pulse per change.
